// File: rtl/ysyx_23060184_wb_stage_pkg.sv
// Shared constants for the ysyx_23060184 writeback stage: widths,
// writeback source codes and FSM state encoding.
package ysyx_23060184_wb_stage_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int REG_ADDR_WIDTH    = 5;
    localparam int RESULT_SRC_LENGTH = 3;
    localparam int RETIRE_CNT_WIDTH  = 64;

    localparam logic [RESULT_SRC_LENGTH-1:0] WB_SRC_ALU = 3'd0;
    localparam logic [RESULT_SRC_LENGTH-1:0] WB_SRC_MEM = 3'd1;
    localparam logic [RESULT_SRC_LENGTH-1:0] WB_SRC_PC4 = 3'd2;
    localparam logic [RESULT_SRC_LENGTH-1:0] WB_SRC_CSR = 3'd3;
    localparam logic [RESULT_SRC_LENGTH-1:0] WB_SRC_IMM = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WB     = 2'd1,
        ST_RETIRE = 2'd2
    } wb_state_e;

endpackage

// File: rtl/ysyx_23060184_wb_stage_if.sv
// Upstream (memory -> writeback) and downstream (writeback -> fetch) handshakes.
// Both handshakes: a transfer happens on the rising edge where valid && ready;
// the sender holds valid and payload stable until then, and ready never waits on valid.
interface ysyx_23060184_wb_stage_if
    import ysyx_23060184_wb_stage_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = REG_ADDR_WIDTH
) ();
    logic                         mem_valid;
    logic                         wb_ready;
    logic [DW-1:0]                mem_result;
    logic [DW-1:0]                alu_result;
    logic [DW-1:0]                csr_rdata;
    logic [DW-1:0]                imm;
    logic [DW-1:0]                pc;
    logic [DW-1:0]                next_pc;
    logic [RESULT_SRC_LENGTH-1:0] result_src;
    logic [AW-1:0]                rd;
    logic                         reg_write;
    logic                         wb_valid;
    logic                         fetch_ready;
    logic [DW-1:0]                fetch_pc;

    modport master (
        output mem_valid, mem_result, alu_result, csr_rdata, imm, pc, next_pc,
               result_src, rd, reg_write, fetch_ready,
        input  wb_ready, wb_valid, fetch_pc
    );

    modport slave (
        input  mem_valid, mem_result, alu_result, csr_rdata, imm, pc, next_pc,
               result_src, rd, reg_write, fetch_ready,
        output wb_ready, wb_valid, fetch_pc
    );
endinterface

// File: rtl/ysyx_23060184_regfile.sv
// Integer register file: two combinational read ports, one synchronous write
// port with same-cycle write bypass, x0 hardwired to zero.
module ysyx_23060184_regfile
    import ysyx_23060184_wb_stage_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = REG_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);
    logic [DW-1:0] regs [2**AW];
    logic          wr_live;

    assign wr_live = we && (waddr != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2**AW; i++) regs[i] <= '0;
        end else if (wr_live) begin
            regs[waddr] <= wdata;
        end
    end

    // Readers in the write cycle see the value about to land.
    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] a);
        if (a == '0)                   return '0;
        else if (wr_live && a == waddr) return wdata;
        else                           return regs[a];
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end
endmodule

// File: rtl/ysyx_23060184_wb_stage.sv
// Writeback stage: accept one instruction, write the register file, hand the
// next PC to fetch, count retirements. IDLE -> WB -> RETIRE.
module ysyx_23060184_wb_stage
    import ysyx_23060184_wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH       = ysyx_23060184_wb_stage_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH   = ysyx_23060184_wb_stage_pkg::REG_ADDR_WIDTH,
    parameter int RETIRE_CNT_WIDTH = ysyx_23060184_wb_stage_pkg::RETIRE_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        resetn,
    ysyx_23060184_wb_stage_if.slave     bus,
    input  logic [REG_ADDR_WIDTH-1:0]   rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0]   rs2_addr,
    output logic [DATA_WIDTH-1:0]       rs1_data,
    output logic [DATA_WIDTH-1:0]       rs2_data,
    output logic [RETIRE_CNT_WIDTH-1:0] retire_cnt,
    output logic [1:0]                  dbg_state
);
    wb_state_e                    state;
    logic                         wb_ready_q;
    logic                         wb_valid_q;
    logic [DATA_WIDTH-1:0]        fetch_pc_q;
    logic [RETIRE_CNT_WIDTH-1:0]  retire_cnt_q;

    logic [DATA_WIDTH-1:0]        l_alu, l_mem, l_csr, l_imm, l_pc, l_next_pc;
    logic [RESULT_SRC_LENGTH-1:0] l_src;
    logic [REG_ADDR_WIDTH-1:0]    l_rd;
    logic                         l_reg_write;

    logic [DATA_WIDTH-1:0]        wb_data;
    logic                         rf_we;

    always_comb begin
        wb_data = '0;
        case (l_src)
            WB_SRC_ALU: wb_data = l_alu;
            WB_SRC_MEM: wb_data = l_mem;
            WB_SRC_PC4: wb_data = l_pc + DATA_WIDTH'(4);
            WB_SRC_CSR: wb_data = l_csr;
            WB_SRC_IMM: wb_data = l_imm;
            default:    wb_data = '0;
        endcase
    end

    assign rf_we = (state == ST_WB) && l_reg_write && (l_rd != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            wb_ready_q   <= 1'b1;
            wb_valid_q   <= 1'b0;
            fetch_pc_q   <= '0;
            retire_cnt_q <= '0;
            l_alu        <= '0;
            l_mem        <= '0;
            l_csr        <= '0;
            l_imm        <= '0;
            l_pc         <= '0;
            l_next_pc    <= '0;
            l_src        <= '0;
            l_rd         <= '0;
            l_reg_write  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.mem_valid && wb_ready_q) begin
                        l_alu       <= bus.alu_result;
                        l_mem       <= bus.mem_result;
                        l_csr       <= bus.csr_rdata;
                        l_imm       <= bus.imm;
                        l_pc        <= bus.pc;
                        l_next_pc   <= bus.next_pc;
                        l_src       <= bus.result_src;
                        l_rd        <= bus.rd;
                        l_reg_write <= bus.reg_write;
                        wb_ready_q  <= 1'b0;
                        state       <= ST_WB;
                    end
                end
                ST_WB: begin
                    fetch_pc_q <= l_next_pc;
                    wb_valid_q <= 1'b1;
                    state      <= ST_RETIRE;
                end
                ST_RETIRE: begin
                    // fetch_pc is untouched here, so it stays stable under backpressure.
                    if (bus.fetch_ready) begin
                        retire_cnt_q <= retire_cnt_q + RETIRE_CNT_WIDTH'(1);
                        wb_valid_q   <= 1'b0;
                        wb_ready_q   <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    wb_valid_q <= 1'b0;
                    wb_ready_q <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wb_ready = wb_ready_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.fetch_pc = fetch_pc_q;
    assign retire_cnt   = retire_cnt_q;
    assign dbg_state    = state;

    ysyx_23060184_regfile #(
        .DW (DATA_WIDTH),
        .AW (REG_ADDR_WIDTH)
    ) u_regfile (
        .clk    (clk),
        .resetn (resetn),
        .we     (rf_we),
        .waddr  (l_rd),
        .wdata  (wb_data),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );
endmodule

// File: tb/tb_ysyx_23060184_wb_stage.sv
// Bench for the writeback stage: directed vector table, mid-operation reset,
// then random transactions against a register-array reference model.
module tb_ysyx_23060184_wb_stage;
    import ysyx_23060184_wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [63:0] retire_cnt;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    ysyx_23060184_wb_stage_if bus ();

    ysyx_23060184_wb_stage dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .retire_cnt (retire_cnt),
        .dbg_state  (dbg_state)
    );

    typedef struct {
        logic [2:0]  src;
        logic [31:0] alu, mem, csr, imm, pc, npc;
        logic [4:0]  rd;
        logic        rw;
        int          stall;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] model_rf[32];
    logic [63:0] model_cnt;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Data goes into the field the source selects; other fields carry junk.
    function automatic vec_t mk(input logic [2:0] src, input logic [31:0] data,
                                input logic [31:0] pc, input logic [31:0] npc,
                                input logic [4:0] rd, input logic rw,
                                input int stall, input logic [31:0] exp);
        vec_t v;
        v.src = src; v.pc = pc; v.npc = npc; v.rd = rd; v.rw = rw;
        v.stall = stall; v.exp = exp;
        v.alu = 32'h0A1A_0A1A; v.mem = 32'h0B2B_0B2B;
        v.csr = 32'h0C3C_0C3C; v.imm = 32'h0D4D_0D4D;
        case (src)
            3'd0: v.alu = data;
            3'd1: v.mem = data;
            3'd3: v.csr = data;
            3'd4: v.imm = data;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_value(input vec_t v);
        case (v.src)
            3'd0: return v.alu;
            3'd1: return v.mem;
            3'd2: return v.pc + 32'd4;
            3'd3: return v.csr;
            3'd4: return v.imm;
            default: return 32'd0;
        endcase
    endfunction

    task automatic scramble_inputs();
        bus.alu_result = $urandom; bus.mem_result = $urandom;
        bus.csr_rdata  = $urandom; bus.imm        = $urandom;
        bus.pc         = $urandom; bus.next_pc    = $urandom;
        bus.result_src = 3'($urandom_range(0, 7));
        bus.rd         = 5'($urandom_range(0, 31));
        bus.reg_write  = 1'($urandom_range(0, 1));
    endtask

    task automatic run_txn(input vec_t v, input logic [31:0] exp);
        logic [31:0] old_val;
        @(negedge clk);
        check("idle_ready", bus.wb_ready, 1'b1);
        rs1_addr = v.rd;
        #1;
        old_val = model_rf[v.rd];
        check("pre_read", rs1_data, old_val);
        bus.alu_result = v.alu; bus.mem_result = v.mem; bus.csr_rdata = v.csr;
        bus.imm = v.imm; bus.pc = v.pc; bus.next_pc = v.npc;
        bus.result_src = v.src; bus.rd = v.rd; bus.reg_write = v.rw;
        bus.mem_valid = 1'b1;
        bus.fetch_ready = (v.stall == 0);
        @(posedge clk);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        scramble_inputs();
        check("wb_ready_in_wb", bus.wb_ready, 1'b0);
        check("wb_valid_in_wb", bus.wb_valid, 1'b0);
        #1;
        if (v.rw && v.rd != 5'd0) model_rf[v.rd] = exp;
        check("bypass_read", rs1_data, model_rf[v.rd]);
        @(posedge clk);
        @(negedge clk);
        check("wb_valid", bus.wb_valid, 1'b1);
        check("fetch_pc", bus.fetch_pc, v.npc);
        check("wb_ready_retire", bus.wb_ready, 1'b0);
        check("rf_after_write", rs1_data, model_rf[v.rd]);
        for (int i = 1; i < v.stall; i++) begin
            bus.mem_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", bus.wb_valid, 1'b1);
            check("stall_fetch_pc", bus.fetch_pc, v.npc);
            check("stall_ready", bus.wb_ready, 1'b0);
            check("stall_cnt", retire_cnt, model_cnt);
        end
        bus.fetch_ready = 1'b1;
        bus.mem_valid = 1'b0;
        @(posedge clk);
        model_cnt = model_cnt + 64'd1;
        @(negedge clk);
        check("post_valid", bus.wb_valid, 1'b0);
        check("post_ready", bus.wb_ready, 1'b1);
        check("post_state", dbg_state, ST_IDLE);
        check("retire_cnt", retire_cnt, model_cnt);
        rs2_addr = 5'($urandom_range(0, 31));
        #1;
        check("rs2_read", rs2_data, model_rf[rs2_addr]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t rv;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        model_cnt = 64'd0;
        bus.mem_valid = 1'b0; bus.fetch_ready = 1'b1;
        scramble_inputs();
        rs1_addr = 5'd5; rs2_addr = 5'd0;

        vecs[0] = mk(WB_SRC_ALU, 32'h1234_5678, 32'h8000_0000, 32'h8000_0004, 5'd5,  1'b1, 0, 32'h1234_5678);
        vecs[1] = mk(WB_SRC_ALU, 32'hFFFF_FFFF, 32'h8000_0004, 32'h8000_0008, 5'd0,  1'b1, 0, 32'hFFFF_FFFF);
        vecs[2] = mk(WB_SRC_PC4, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 5'd1,  1'b1, 0, 32'h0000_0000);
        vecs[3] = mk(WB_SRC_ALU, 32'hCAFE_F00D, 32'h8000_0010, 32'h8000_0100, 5'd10, 1'b1, 4, 32'hCAFE_F00D);
        vecs[4] = mk(WB_SRC_MEM, 32'hFFFF_FF80, 32'h8000_0100, 32'h8000_0104, 5'd7,  1'b1, 0, 32'hFFFF_FF80);
        vecs[5] = mk(WB_SRC_CSR, 32'h0000_1800, 32'h8000_0104, 32'h8000_0108, 5'd8,  1'b1, 1, 32'h0000_1800);
        vecs[6] = mk(3'd6,       32'h0,         32'h8000_0108, 32'h8000_010C, 5'd9,  1'b1, 0, 32'h0000_0000);
        vecs[7] = mk(WB_SRC_IMM, 32'hABCD_E000, 32'h8000_010C, 32'h8000_0110, 5'd12, 1'b1, 2, 32'hABCD_E000);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", bus.wb_ready, 1'b1);
        check("rst_valid", bus.wb_valid, 1'b0);
        check("rst_fetch_pc", bus.fetch_pc, 32'd0);
        check("rst_cnt", retire_cnt, 64'd0);
        check("rst_rf", rs1_data, 32'd0);
        resetn = 1'b1;

        foreach (vecs[i]) run_txn(vecs[i], vecs[i].exp);

        // Reset asserted during WB aborts the instruction
        @(negedge clk);
        bus.alu_result = 32'hAA; bus.result_src = WB_SRC_ALU; bus.rd = 5'd3;
        bus.reg_write = 1'b1; bus.next_pc = 32'h8000_0200; bus.mem_valid = 1'b1;
        bus.fetch_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        check("pre_abort_state", dbg_state, ST_WB);
        #2 resetn = 1'b0;
        #1;
        check("abort_ready", bus.wb_ready, 1'b1);
        check("abort_valid", bus.wb_valid, 1'b0);
        check("abort_fetch_pc", bus.fetch_pc, 32'd0);
        check("abort_cnt", retire_cnt, 64'd0);
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        model_cnt = 64'd0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        rs1_addr = 5'd3; rs2_addr = 5'd5;
        #1;
        check("abort_x3", rs1_data, 32'd0);
        check("abort_x5", rs2_data, 32'd0);
        @(negedge clk);
        check("abort_no_retire", retire_cnt, 64'd0);

        // Random transactions against the reference model
        for (int n = 0; n < 24; n++) begin
            rv = mk(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 32'd0);
            rv.alu = $urandom; rv.mem = $urandom; rv.csr = $urandom; rv.imm = $urandom;
            if (n % 6 == 0) rv.pc = 32'hFFFF_FFFC;
            run_txn(rv, ref_value(rv));
        end

        // Final sweep of the whole register file
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            rs2_addr = 5'(i);
            #1;
            check("sweep", rs2_data, model_rf[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_23060184_wb_stage.md
Name: ysyx_23060184_wb_stage

Overview:
- Writeback stage directly downstream of the data-memory stage in the multicycle ysyx_23060184 core.
- Accepts one completed instruction per valid/ready handshake and selects the writeback value (ALU, load result, PC+4, CSR, immediate).
- Writes the 32-entry integer register file, with x0 hardwired to zero.
- Hands next_pc to the fetch stage through a second valid/ready handshake, and counts retired instructions.

Parameters:
- DATA_WIDTH, 32, datapath and register width.
- REG_ADDR_WIDTH, 5, register index width; the register file has 2**REG_ADDR_WIDTH entries.
- RETIRE_CNT_WIDTH, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_valid  in  1  upstream instruction valid; this is the data-memory stage's Wvalid.
- wb_ready  out  1  stage can accept; drives the data-memory stage's Pready.
- mem_result  in  DATA_WIDTH  load data, already extended.
- alu_result  in  DATA_WIDTH  execute result.
- csr_rdata  in  DATA_WIDTH  CSR read value.
- imm  in  DATA_WIDTH  immediate (LUI).
- pc  in  DATA_WIDTH  instruction PC.
- next_pc  in  DATA_WIDTH  resolved next PC.
- result_src  in  3  writeback source select.
- rd  in  REG_ADDR_WIDTH  destination register.
- reg_write  in  1  register write enable.
- rs1_addr, rs2_addr  in  REG_ADDR_WIDTH each  decode-stage read addresses.
- rs1_data, rs2_data  out  DATA_WIDTH each  combinational read data.
- wb_valid  out  1  retire valid to fetch.
- fetch_ready  in  1  fetch stage accepts next PC.
- fetch_pc  out  DATA_WIDTH  PC handed to fetch.
- retire_cnt  out  RETIRE_CNT_WIDTH  count of retired instructions.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, wb_ready=1, wb_valid=0, fetch_pc=0, retire_cnt=0.
  - All register-file entries = 0; all latched fields = 0.
  - Reset asserted mid-operation aborts the instruction: no register write, no retire.
- FSM, one-hot or binary, with three states:
  - IDLE: wb_ready=1. Accept on the rising edge where mem_valid && wb_ready. At that edge latch result_src, rd, reg_write, next_pc and all data inputs; next state is WB. mem_valid held low leaves the stage in IDLE.
  - WB: exactly one cycle, wb_ready=0. The register file writes the selected value at the edge ending WB when latched reg_write && latched rd!=0. Next state is RETIRE; fetch_pc <= latched next_pc at the same edge.
  - RETIRE: wb_valid=1, wb_ready=0. fetch_pc is held stable while wb_valid=1 && !fetch_ready. On wb_valid && fetch_ready: retire_cnt += 1 (wraps modulo 2**RETIRE_CNT_WIDTH), next state is IDLE.
- Minimum latency: accept edge N, register write at edge N+1, wb_valid high from cycle N+2. Back-to-back throughput is one instruction per 3 cycles.
- Writeback select, using latched values (constants from package):
  - 0 ALU: alu_result.
  - 1 MEM: mem_result.
  - 2 PC4: pc+4, truncated to DATA_WIDTH (wraps at 0xFFFFFFFC -> 0).
  - 3 CSR: csr_rdata.
  - 4 IMM: imm.
  - 5-7: 0.
- Register file read ports are combinational:
  - Address 0 always reads 0.
  - Write bypass: during WB, if rsN_addr == latched rd && latched reg_write && rd!=0, rsN_data returns the value being written.
  - Writes to x0 are ignored silently.
- Data inputs are sampled only at the accept edge; upstream changes afterwards have no effect.
- mem_valid is ignored whenever wb_ready=0; no accept while busy.

Decomposition:
- Shared package/header defines: DATA_WIDTH, REG_ADDR_WIDTH, RESULT_SRC_LENGTH=3, the result-source codes WB_SRC_ALU/MEM/PC4/CSR/IMM, and the FSM state encodings.
- One sub-module: ysyx_23060184_regfile, with 2 async read ports, 1 sync write port with write bypass, x0 hardwired, async active-low reset.

Test Plan:
- Basic ALU writeback:
  - Stimulus: reset release; mem_valid=1, result_src=ALU, alu_result=0x12345678, rd=5, reg_write=1, next_pc=0x80000004; fetch_ready=1.
  - Required: wb_ready drops after the accept edge; x5=0x12345678 one edge later; wb_valid=1 with fetch_pc=0x80000004 the next cycle; retire_cnt=1.
- x0 write suppression:
  - Stimulus: rd=0, reg_write=1, alu_result=0xFFFFFFFF.
  - Required: rs1_addr=0 reads 0 before and after; retire_cnt still increments.
- PC+4 wrap and bypass:
  - Stimulus: result_src=PC4, pc=0xFFFFFFFC, rd=1; rs1_addr=1 during WB.
  - Required: rs1_data=0x00000000 in the WB cycle and afterwards.
- Fetch backpressure:
  - Stimulus: fetch_ready=0 for 4 cycles, then 1.
  - Required: wb_valid held high with fetch_pc stable for 4 cycles; wb_ready=0 throughout; mem_valid pulses in this window are not accepted; retire_cnt increments once.
- Load and CSR sources:
  - Stimulus: result_src=MEM with mem_result=0xFFFFFF80, rd=7; then CSR with csr_rdata=0x1800, rd=8; then result_src=6 with rd=9.
  - Required: x7=0xFFFFFF80, x8=0x1800, x9=0.
- Reset mid-operation:
  - Stimulus: assert resetn=0 asynchronously in WB with reg_write=1, rd=3, alu_result=0xAA.
  - Required: outputs return to reset values immediately (wb_ready=1, wb_valid=0, fetch_pc=0, retire_cnt=0); x3=0; no retire.
